complex_mul_serial: RTL
=======================

Name: complex_mul_serial

Overview:
- Time-multiplexed complex multiplier: one signed real multiplier and one accumulator, four cycles per product.
- Consumer-side counterpart to the SDFT complex-rotation stimulus.
- Accepts operand pairs over a valid/ready handshake and returns full-precision results over a valid/ready handshake.
- A per-transaction conj flag multiplies by conj(b), giving the de-rotation (inverse twiddle) direction without negating b.

Parameters:
- W, 8, signed width of each input component.
- OW, 2*W+1, signed width of each output component; must be >= 2*W+1 so no overflow is possible.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept operands (high only in IDLE).
- conj  in  1  sampled with operands; 1 = a*conj(b).
- a_real, a_imag, b_real, b_imag  in  W each  signed operands.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- out_real, out_imag  out  OW each  signed result.

Behaviour:
- Reset (asserted at any time, including mid-operation): state=IDLE, out_valid=0, out_real=0, out_imag=0, in_ready=1. Any in-flight transaction is discarded and never emitted.
- States: IDLE, P0, P1, P2, P3, DONE. in_ready = (state==IDLE), decoded combinationally from state.
- Accept: IDLE with in_valid=1 at an edge:
  - latch the four operands and conj into internal registers;
  - clear both accumulators;
  - go to P0.
  - Operand inputs are don't-care after acceptance.
- Products are sign-extended to OW before accumulation. Let s = +1 if conj=0, -1 if conj=1.
  - P0: acc_r += ar*br; go to P1.
  - P1: acc_r += -s*(ai*bi); go to P2.
  - P2: acc_i += s*(ar*bi); go to P3.
  - P3: acc_i += ai*br; go to DONE. out_real/out_imag load the final sums on this same edge.
- Sign handling: the sign is applied by choosing add vs subtract of the product. b_imag is never negated, so b_imag = -2^(W-1) is exact.
- Results:
  - conj=0: real = ar*br - ai*bi, imag = ar*bi + ai*br.
  - conj=1: real = ar*br + ai*bi, imag = ai*br - ar*bi.
- DONE:
  - out_valid=1; out_real/out_imag held stable while out_ready=0, for any number of cycles.
  - On an edge with out_ready=1: out_valid falls and state returns to IDLE. out_real/out_imag keep their last values, don't-care when out_valid=0.
- Latency: out_valid rises exactly 4 edges after the accepting edge. A result is consumed on the 5th edge at earliest.
- in_ready rises on the edge after output acceptance. Minimum 6 cycles per transaction.
- No overlap: a new input is never accepted while out_valid=1, even if out_ready=1 in the same cycle.
- Handshake inputs are ignored outside their own states: in_valid outside IDLE, out_ready outside DONE.

Test Plan:
- Basic: a=3+1j, b=2-1j, conj=0, out_ready=1 -> after 4 edges out_valid=1 with out=7-1j; in_ready low for P0..DONE, high the cycle after output handshake.
- Conjugate: a=3+1j, b=2-1j, conj=1 -> out=5+5j. Then a=-3-3j, b=-2-2j, conj=0 -> out=0+12j.
- Extremes: a=b=-128-128j, conj=0 -> out_real=0, out_imag=32768 (no wrap in 17 bits). Same operands with conj=1 -> out_real=32768, out_imag=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out stable, in_ready stays 0 even with in_valid=1. Release -> one handshake, then back to IDLE.
- Operand independence: change a/b/conj every cycle after acceptance -> result equals the value for the operands sampled at accept.
- Reset mid-operation: assert reset asynchronously during P2 -> out_valid=0, outputs 0, in_ready=1 immediately. No stale result appears after release. The next transaction (3+1j)(2-1j) returns 7-1j.

Source files
------------

// File: rtl/complex_mul_serial.sv
// rtl/complex_mul_serial.sv - serial complex multiplier, one real multiplier, four cycles per product
// Accepts a, b and conj in IDLE, accumulates four partial products in P0..P3, then holds the result in DONE.
module complex_mul_serial #(
  parameter int W  = 8,
  parameter int OW = 2*W+1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          conj,
  input  logic [W-1:0]  a_real,
  input  logic [W-1:0]  a_imag,
  input  logic [W-1:0]  b_real,
  input  logic [W-1:0]  b_imag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_real,
  output logic [OW-1:0] out_imag
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    P3   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic signed [W-1:0]  ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
  logic                 conj_q, conj_d;
  logic signed [OW-1:0] acc_r_q, acc_r_d, acc_i_q, acc_i_d;
  logic signed [OW-1:0] out_real_q, out_real_d, out_imag_q, out_imag_d;

  logic signed [W-1:0]   mul_a, mul_b;
  logic signed [2*W-1:0] prod;
  logic signed [OW-1:0]  prod_ext;
  logic                  prod_sub;

  // Operand steering for the shared multiplier; prod_sub applies the sign so b_imag is never negated.
  always_comb begin
    mul_a    = ar_q;
    mul_b    = br_q;
    prod_sub = 1'b0;
    case (state_q)
      P1: begin
        mul_a    = ai_q;
        mul_b    = bi_q;
        prod_sub = ~conj_q;
      end
      P2: begin
        mul_a    = ar_q;
        mul_b    = bi_q;
        prod_sub = conj_q;
      end
      P3: begin
        mul_a    = ai_q;
        mul_b    = br_q;
      end
      default: ;
    endcase
  end

  assign prod     = mul_a * mul_b;
  assign prod_ext = {{(OW-2*W){prod[2*W-1]}}, prod};

  always_comb begin
    state_d    = state_q;
    ar_d       = ar_q;
    ai_d       = ai_q;
    br_d       = br_q;
    bi_d       = bi_q;
    conj_d     = conj_q;
    acc_r_d    = acc_r_q;
    acc_i_d    = acc_i_q;
    out_real_d = out_real_q;
    out_imag_d = out_imag_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ar_d    = $signed(a_real);
          ai_d    = $signed(a_imag);
          br_d    = $signed(b_real);
          bi_d    = $signed(b_imag);
          conj_d  = conj;
          acc_r_d = '0;
          acc_i_d = '0;
          state_d = P0;
        end
      end
      P0: begin
        acc_r_d = acc_r_q + prod_ext;
        state_d = P1;
      end
      P1: begin
        acc_r_d = prod_sub ? acc_r_q - prod_ext : acc_r_q + prod_ext;
        state_d = P2;
      end
      P2: begin
        acc_i_d = prod_sub ? acc_i_q - prod_ext : acc_i_q + prod_ext;
        state_d = P3;
      end
      P3: begin
        acc_i_d    = acc_i_q + prod_ext;
        out_real_d = acc_r_q;
        out_imag_d = acc_i_q + prod_ext;
        state_d    = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ar_q       <= '0;
      ai_q       <= '0;
      br_q       <= '0;
      bi_q       <= '0;
      conj_q     <= 1'b0;
      acc_r_q    <= '0;
      acc_i_q    <= '0;
      out_real_q <= '0;
      out_imag_q <= '0;
    end else begin
      state_q    <= state_d;
      ar_q       <= ar_d;
      ai_q       <= ai_d;
      br_q       <= br_d;
      bi_q       <= bi_d;
      conj_q     <= conj_d;
      acc_r_q    <= acc_r_d;
      acc_i_q    <= acc_i_d;
      out_real_q <= out_real_d;
      out_imag_q <= out_imag_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_real  = out_real_q;
  assign out_imag  = out_imag_q;

endmodule
